stack_transfer_sequencer: RTL and testbench

//  Multi-register PUSH/POP sequencer between the decoder and RegBank/data memory.

---
 rtl/stack_transfer_sequencer_if.sv | 46 ++++
 rtl/stack_transfer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_stack_transfer_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_transfer_sequencer_if.sv
// Bundle between the instruction decoder / RegBank / data memory and the
// PUSH/POP sequencer. The master side issues requests and supplies RegBank and
// memory read data. The slave side is the sequencer, which drives the transfer
// strobes.
interface stack_transfer_sequencer_if #(
    parameter int REGISTER_LENGTH = 32,
    parameter int ADDR_WIDTH      = 14
);
    logic                       start;
    logic                       is_pop;
    logic [7:0]                 register_list;
    logic                       extra_bit;
    logic [REGISTER_LENGTH-1:0] current_SP;
    logic [REGISTER_LENGTH-1:0] register_data;
    logic [REGISTER_LENGTH-1:0] data_from_memory;

    logic                       busy;
    logic                       done;
    logic [3:0]                 register_Dest;
    logic                       write_register;
    logic                       mem_read;
    logic                       mem_write;
    logic [ADDR_WIDTH-1:0]      mem_address;
    logic [REGISTER_LENGTH-1:0] mem_write_data;
    logic                       pc_load;
    logic [ADDR_WIDTH-1:0]      pc_value;
    logic                       sp_write;
    logic [REGISTER_LENGTH-1:0] new_SP;
    logic                       stack_fault;

    modport master (
        output start, is_pop, register_list, extra_bit, current_SP,
               register_data, data_from_memory,
        input  busy, done, register_Dest, write_register, mem_read, mem_write,
               mem_address, mem_write_data, pc_load, pc_value, sp_write,
               new_SP, stack_fault
    );

    modport slave (
        input  start, is_pop, register_list, extra_bit, current_SP,
               register_data, data_from_memory,
        output busy, done, register_Dest, write_register, mem_read, mem_write,
               mem_address, mem_write_data, pc_load, pc_value, sp_write,
               new_SP, stack_fault
    );
endinterface

// File: rtl/stack_transfer_sequencer.sv
// Expands a single PUSH {rlist[,LR]} or POP {rlist[,PC]} into one memory
// transfer per selected register on an empty-descending, word-addressed stack.
// A PUSH stores the highest register first (LR, then R7..R0) at SP and
// decrements SP after each store. A POP first increments SP and then reads,
// filling the lowest register first (R0..R7, then PC). The final SP is
// reported once in DONE.
module stack_transfer_sequencer #(
    parameter int                         REGISTER_LENGTH = 32,
    parameter int                         ADDR_WIDTH      = 14,
    parameter logic [REGISTER_LENGTH-1:0] MAX_NUMBER      = 32'hffffffff
) (
    input  logic                      slow_clock,
    input  logic                      reset,
    stack_transfer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_XFER,
        POP_ADDR,
        POP_CAPT,
        DONE
    } state_t;

    localparam logic [REGISTER_LENGTH-1:0] SP_ONE = 1;

    state_t                     state, state_next;
    logic [8:0]                 mask, mask_next;
    logic [REGISTER_LENGTH-1:0] sp_work, sp_next;
    logic                       fault, fault_next;
    logic [REGISTER_LENGTH-1:0] sp_inc;

    logic [3:0]                 push_idx;
    logic [8:0]                 push_bit;
    logic [3:0]                 pop_idx;
    logic [8:0]                 pop_bit;

    // Only the low address bits of a popped word matter here (as a PC target).
    // The full word goes straight to RegBank, so the upper bits are
    // intentionally left unused.
    logic                       unused_data_bits;
    assign unused_data_bits = ^bus.data_from_memory[REGISTER_LENGTH-1:ADDR_WIDTH];

    assign sp_inc = sp_work + SP_ONE;

    // Pick the next register to store: LR wins, otherwise the highest R7..R0 bit.
    always_comb begin
        push_idx = '0;
        push_bit = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                push_idx    = 4'(i);
                push_bit    = '0;
                push_bit[i] = 1'b1;
            end
        end
        if (mask[8]) begin
            push_idx = 4'd14;
            push_bit = 9'h100;
        end
    end

    // Pick the next register to load: lowest R0..R7 bit, PC only once those are gone.
    always_comb begin
        pop_idx = '0;
        pop_bit = '0;
        if (mask[8]) begin
            pop_idx = 4'd15;
            pop_bit = 9'h100;
        end
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                pop_idx    = 4'(i);
                pop_bit    = '0;
                pop_bit[i] = 1'b1;
            end
        end
    end

    // Next-state, working-register updates and all transfer strobes.
    always_comb begin
        state_next         = state;
        mask_next          = mask;
        sp_next            = sp_work;
        fault_next         = fault;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.register_Dest  = '0;
        bus.write_register = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.pc_load        = 1'b0;
        bus.pc_value       = '0;
        bus.sp_write       = 1'b0;
        bus.new_SP         = '0;
        bus.stack_fault    = fault;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    mask_next  = {bus.extra_bit, bus.register_list};
                    sp_next    = bus.current_SP;
                    fault_next = 1'b0;
                    if ({bus.extra_bit, bus.register_list} == 9'd0) begin
                        state_next = DONE;
                    end else if (bus.is_pop) begin
                        state_next = POP_ADDR;
                    end else begin
                        state_next = PUSH_XFER;
                    end
                end
            end

            PUSH_XFER: begin
                bus.busy           = 1'b1;
                bus.register_Dest  = push_idx;
                bus.mem_write      = 1'b1;
                bus.mem_address    = sp_work[ADDR_WIDTH-1:0];
                bus.mem_write_data = bus.register_data;
                sp_next            = sp_work - SP_ONE;
                mask_next          = mask & ~push_bit;
                if ((mask & ~push_bit) == 9'd0) begin
                    state_next = DONE;
                end
            end

            POP_ADDR: begin
                bus.busy        = 1'b1;
                bus.mem_read    = 1'b1;
                bus.mem_address = sp_inc[ADDR_WIDTH-1:0];
                sp_next         = sp_inc;
                if (sp_work == MAX_NUMBER) begin
                    fault_next = 1'b1;
                end
                state_next = POP_CAPT;
            end

            POP_CAPT: begin
                bus.busy          = 1'b1;
                bus.register_Dest = pop_idx;
                if (pop_idx == 4'd15) begin
                    bus.pc_load  = 1'b1;
                    bus.pc_value = bus.data_from_memory[ADDR_WIDTH-1:0];
                end else begin
                    bus.write_register = 1'b1;
                end
                mask_next = mask & ~pop_bit;
                if ((mask & ~pop_bit) == 9'd0) begin
                    state_next = DONE;
                end else begin
                    state_next = POP_ADDR;
                end
            end

            DONE: begin
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
                bus.sp_write = 1'b1;
                bus.new_SP   = sp_work;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and working registers; reset abandons any sequence in flight.
    always_ff @(posedge slow_clock) begin
        if (!reset) begin
            state   <= IDLE;
            mask    <= '0;
            sp_work <= '0;
            fault   <= 1'b0;
        end else begin
            state   <= state_next;
            mask    <= mask_next;
            sp_work <= sp_next;
            fault   <= fault_next;
        end
    end

endmodule

// File: tb/tb_stack_transfer_sequencer.sv
// Self-checking bench for stack_transfer_sequencer. The bench plays the
// decoder, RegBank and data memory. A list-level model predicts every
// transfer, the final SP, the fault flag and the latency of each request.
module tb_stack_transfer_sequencer;

    typedef struct {
        logic [3:0]  idx;
        logic [13:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic slow_clock = 1'b0;
    logic reset      = 1'b0;

    stack_transfer_sequencer_if #(.REGISTER_LENGTH(32), .ADDR_WIDTH(14)) bus ();

    stack_transfer_sequencer #(
        .REGISTER_LENGTH(32),
        .ADDR_WIDTH(14),
        .MAX_NUMBER(32'hffffffff)
    ) dut (
        .slow_clock(slow_clock),
        .reset(reset),
        .bus(bus.slave)
    );

    // Free-running clock.
    always #5 slow_clock = ~slow_clock;

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] rf      [0:15];
    logic [31:0] ref_rf  [0:15];
    xfer_t       exp_q[$];

    int          assert_count;
    int          fail_count;
    logic [31:0] model_sp;
    logic [31:0] obs_new_sp;
    logic [13:0] last_pc;
    logic [13:0] last_read_addr;
    int          writes_seen;
    int          reads_seen;
    int          caps_seen;

    assign bus.register_data = rf[bus.register_Dest];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pop, input logic [7:0] list, input logic ext,
                                 input logic [31:0] sp, input int pulse_at, input int abort_after);
        logic [31:0] exp_sp;
        logic        exp_fault;
        logic [31:0] a;
        int          n;
        int          lat;
        int          last_cyc;
        bit          finished;
        xfer_t       x;

        exp_q.delete();
        n         = 0;
        exp_fault = 1'b0;
        if (!pop) begin
            for (int r = 15; r >= 0; r--) begin
                if ((r < 8 && list[r]) || (r == 14 && ext)) begin
                    a = sp - 32'(n);
                    exp_q.push_back('{4'(r), a[13:0], ref_rf[r]});
                    n++;
                end
            end
            exp_sp = sp - 32'(n);
        end else begin
            for (int r = 0; r < 16; r++) begin
                if ((r < 8 && list[r]) || (r == 15 && ext)) begin
                    if (sp + 32'(n) == 32'hffffffff) exp_fault = 1'b1;
                    a = sp + 32'(n) + 32'd1;
                    exp_q.push_back('{4'(r), a[13:0], ref_mem[a[13:0]]});
                    n++;
                end
            end
            exp_sp = sp + 32'(n);
        end
        lat = (n == 0) ? 1 : (pop ? 2 * n + 1 : n + 1);

        writes_seen = 0;
        reads_seen  = 0;
        caps_seen   = 0;
        finished    = 0;
        last_cyc    = 0;

        @(negedge slow_clock);
        bus.start         = 1'b1;
        bus.is_pop        = pop;
        bus.register_list = list;
        bus.extra_bit     = ext;
        bus.current_SP    = sp;

        for (int cyc = 1; cyc <= 40 && !finished; cyc++) begin
            @(negedge slow_clock);
            last_cyc = cyc;
            checkOutput("one_strobe",
                32'((32'(bus.mem_read) + 32'(bus.mem_write) + 32'(bus.write_register)) <= 32'd1), 32'd1);
            checkOutput("busy", {31'b0, bus.busy}, 32'd1);

            if (bus.mem_write) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    x = exp_q.pop_front();
                    checkOutput("push_dest", {28'b0, bus.register_Dest}, {28'b0, x.idx});
                    checkOutput("push_addr", {18'b0, bus.mem_address}, {18'b0, x.addr});
                    checkOutput("push_data", bus.mem_write_data, x.data);
                    mem[bus.mem_address] = bus.mem_write_data;
                    ref_mem[x.addr]      = x.data;
                end
            end

            if (bus.mem_read) begin
                reads_seen++;
                last_read_addr = bus.mem_address;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_read", 32'(exp_q.size()), 32'd1);
                end else begin
                    checkOutput("pop_addr", {18'b0, bus.mem_address}, {18'b0, exp_q[0].addr});
                end
                bus.data_from_memory = mem[bus.mem_address];
            end

            if (bus.write_register || bus.pc_load) begin
                caps_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_capture", 32'(exp_q.size()), 32'd1);
                end else begin
                    x = exp_q.pop_front();
                    checkOutput("pop_dest", {28'b0, bus.register_Dest}, {28'b0, x.idx});
                    checkOutput("pc_load", {31'b0, bus.pc_load}, {31'b0, x.idx == 4'd15});
                    checkOutput("write_register", {31'b0, bus.write_register}, {31'b0, x.idx != 4'd15});
                    if (bus.write_register) begin
                        checkOutput("pop_data", bus.data_from_memory, x.data);
                        rf[bus.register_Dest] = bus.data_from_memory;
                    end else begin
                        checkOutput("pc_value", {18'b0, bus.pc_value}, {18'b0, x.data[13:0]});
                        last_pc = bus.pc_value;
                    end
                    if (x.idx != 4'd15) ref_rf[x.idx] = x.data;
                end
            end

            if (abort_after > 0 && caps_seen == abort_after) begin
                finished  = 1;
                bus.start = 1'b0;
                reset     = 1'b0;
                exp_q.delete();
                @(negedge slow_clock);
                checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
                checkOutput("abort_done", {31'b0, bus.done}, 32'd0);
                checkOutput("abort_strobes",
                    {29'b0, bus.mem_read, bus.mem_write, bus.write_register}, 32'd0);
                checkOutput("abort_pc_load", {31'b0, bus.pc_load}, 32'd0);
                checkOutput("abort_sp_write", {31'b0, bus.sp_write}, 32'd0);
                checkOutput("abort_new_sp", bus.new_SP, 32'd0);
                checkOutput("abort_addr", {18'b0, bus.mem_address}, 32'd0);
                checkOutput("abort_dest", {28'b0, bus.register_Dest}, 32'd0);
                checkOutput("abort_fault", {31'b0, bus.stack_fault}, 32'd0);
                reset = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge slow_clock);
                    checkOutput("post_abort_quiet",
                        {28'b0, bus.sp_write, bus.mem_read, bus.mem_write, bus.write_register}, 32'd0);
                end
            end else if (bus.done) begin
                finished = 1;
                checkOutput("latency", 32'(cyc), 32'(lat));
                checkOutput("new_SP", bus.new_SP, exp_sp);
                checkOutput("sp_write", {31'b0, bus.sp_write}, 32'd1);
                checkOutput("stack_fault", {31'b0, bus.stack_fault}, {31'b0, exp_fault});
                checkOutput("all_transfers", 32'(exp_q.size()), 32'd0);
                obs_new_sp = bus.new_SP;
                model_sp   = exp_sp;
                bus.start  = 1'b0;
                @(negedge slow_clock);
                checkOutput("idle_busy", {31'b0, bus.busy}, 32'd0);
                checkOutput("idle_done", {31'b0, bus.done}, 32'd0);
                checkOutput("idle_sp_write", {31'b0, bus.sp_write}, 32'd0);
                checkOutput("sticky_fault", {31'b0, bus.stack_fault}, {31'b0, exp_fault});
            end

            if (!finished) begin
                bus.start         = (cyc == pulse_at);
                bus.is_pop        = 1'($urandom_range(0, 1));
                bus.register_list = 8'($urandom);
                bus.extra_bit     = 1'($urandom_range(0, 1));
                bus.current_SP    = $urandom;
            end
        end

        if (!finished) begin
            checkOutput("timeout_cycles", 32'(last_cyc + 1), 32'(lat));
            exp_q.delete();
            bus.start = 1'b0;
        end
    endtask

    // Test sequence: reset, directed scenarios, then randomized requests.
    initial begin
        logic [1:0]  sel;
        logic [7:0]  rlist;
        logic [31:0] rsp;

        assert_count = 0;
        fail_count   = 0;
        model_sp     = 32'hffffffff;
        obs_new_sp   = '0;
        last_pc      = '0;
        last_read_addr = '0;
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 16; i++) begin
            rf[i]     = $urandom;
            ref_rf[i] = rf[i];
        end
        bus.start            = 1'b0;
        bus.is_pop           = 1'b0;
        bus.register_list    = '0;
        bus.extra_bit        = 1'b0;
        bus.current_SP       = '0;
        bus.data_from_memory = '0;

        repeat (2) @(negedge slow_clock);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
        checkOutput("reset_strobes", {28'b0, bus.mem_read, bus.mem_write, bus.write_register, bus.pc_load}, 32'd0);
        checkOutput("reset_sp_write", {31'b0, bus.sp_write}, 32'd0);
        checkOutput("reset_new_sp", bus.new_SP, 32'd0);
        checkOutput("reset_fault", {31'b0, bus.stack_fault}, 32'd0);
        reset = 1'b1;
        @(negedge slow_clock);

        // PUSH {R0,R1,LR} from the empty stack.
        rf[0] = 32'hA;  ref_rf[0] = 32'hA;
        rf[1] = 32'hB;  ref_rf[1] = 32'hB;
        rf[14] = 32'hC; ref_rf[14] = 32'hC;
        applyStimulus(1'b0, 8'h03, 1'b1, 32'hffffffff, 0, 0);
        checkOutput("t1_mem_3fff", mem[14'h3fff], 32'hC);
        checkOutput("t1_mem_3ffe", mem[14'h3ffe], 32'hB);
        checkOutput("t1_mem_3ffd", mem[14'h3ffd], 32'hA);
        checkOutput("t1_new_sp", obs_new_sp, 32'hfffffffc);

        // POP {R0,R1,PC} restores them and branches.
        rf[0] = '0; ref_rf[0] = '0;
        rf[1] = '0; ref_rf[1] = '0;
        applyStimulus(1'b1, 8'h03, 1'b1, 32'hfffffffc, 0, 0);
        checkOutput("t2_r0", rf[0], 32'hA);
        checkOutput("t2_r1", rf[1], 32'hB);
        checkOutput("t2_pc", {18'b0, last_pc}, 32'hC);
        checkOutput("t2_new_sp", obs_new_sp, 32'hffffffff);
        checkOutput("t2_fault", {31'b0, bus.stack_fault}, 32'd0);

        // POP from an empty stack wraps and flags underflow.
        applyStimulus(1'b1, 8'h08, 1'b0, 32'hffffffff, 0, 0);
        checkOutput("t3_fault", {31'b0, bus.stack_fault}, 32'd1);
        checkOutput("t3_addr", {18'b0, last_read_addr}, 32'd0);
        checkOutput("t3_new_sp", obs_new_sp, 32'd0);

        // Empty list: no transfers, SP unchanged.
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h12345678, 0, 0);
        checkOutput("t4_strobes", 32'(writes_seen + reads_seen + caps_seen), 32'd0);
        checkOutput("t4_new_sp", obs_new_sp, 32'h12345678);

        // A second start mid-PUSH is ignored.
        applyStimulus(1'b0, 8'hff, 1'b0, 32'h00001000, 3, 0);
        checkOutput("t5_writes", 32'(writes_seen), 32'd8);
        checkOutput("t5_new_sp", obs_new_sp, 32'h00000ff8);

        // Reset part-way through an 8-register POP, then a fresh request.
        applyStimulus(1'b1, 8'hff, 1'b0, 32'h00000ff8, 0, 3);
        applyStimulus(1'b0, 8'h04, 1'b0, 32'h00002000, 0, 0);
        checkOutput("t6_fresh_writes", 32'(writes_seen), 32'd1);
        checkOutput("t6_fresh_new_sp", obs_new_sp, 32'h00001fff);

        // Randomized requests around the stack edges.
        for (int t = 0; t < 30; t++) begin
            sel   = 2'($urandom_range(0, 3));
            rlist = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            case (sel)
                2'd0:    rsp = model_sp;
                2'd1:    rsp = 32'hffffffff - 32'($urandom_range(0, 4));
                2'd2:    rsp = 32'($urandom_range(0, 4));
                default: rsp = $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), rlist, 1'($urandom_range(0, 1)), rsp, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
